// File: rtl/poly_hint_unpack.sv
// Unpacks an OMEGA+K byte hint field into K 256-coefficient hint polynomials and flags malformed encodings.
// Input is byte-serial under valid/ready; each poly is held on h_out until h_ready.
module poly_hint_unpack #(
  parameter int K     = 4,
  parameter int OMEGA = 80,
  localparam int PW   = (K > 1) ? $clog2(K) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [7:0]      i_in_byte,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  output logic [8191:0]   o_h_out,
  output logic [PW-1:0]   o_h_poly_idx,
  output logic            o_h_valid,
  input  logic            i_h_ready,
  output logic            o_done,
  output logic            o_err
);

  localparam int AW = (OMEGA > 1) ? $clog2(OMEGA) : 1;
  localparam int IW = $clog2(K + 1);
  localparam logic [7:0]    OM  = 8'(OMEGA);
  localparam logic [7:0]    OM1 = 8'(OMEGA - 1);
  localparam logic [IW-1:0] KL  = IW'(K - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_IDX = 3'd1;
  localparam logic [2:0] S_LOAD_CNT = 3'd2;
  localparam logic [2:0] S_SET_BITS = 3'd3;
  localparam logic [2:0] S_EMIT     = 3'd4;
  localparam logic [2:0] S_CHK_TAIL = 3'd5;
  localparam logic [2:0] S_DRAIN    = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]    r_state;
  logic [7:0]    r_buf [0:OMEGA-1];
  logic [7:0]    r_k;
  logic [7:0]    r_j;
  logic [7:0]    r_end;
  logic [IW-1:0] r_i;
  logic [255:0]  r_bits;
  logic          r_err;

  logic [7:0] w_jm1;
  logic [7:0] w_cur;
  logic [7:0] w_prev;
  logic       w_acc;

  assign w_jm1  = r_j - 8'd1;
  assign w_cur  = r_buf[r_j[AW-1:0]];
  assign w_prev = r_buf[w_jm1[AW-1:0]];

  // In DRAIN, ready drops once every count byte of the frame has been consumed.
  assign o_in_ready = (r_state == S_LOAD_IDX) || (r_state == S_LOAD_CNT) ||
                      ((r_state == S_DRAIN) && (r_i != KL));
  assign w_acc        = i_in_valid && o_in_ready;
  assign o_h_valid    = (r_state == S_EMIT);
  assign o_done       = (r_state == S_DONE);
  assign o_err        = r_err;
  assign o_h_poly_idx = r_i[PW-1:0];

  genvar gx;
  generate
    for (gx = 0; gx < 256; gx++) begin : g_coef
      assign o_h_out[32*gx +: 32] = {31'd0, r_bits[gx]};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if ((r_state == S_LOAD_IDX) && w_acc) r_buf[r_j[AW-1:0]] <= i_in_byte;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_k     <= 8'd0;
      r_j     <= 8'd0;
      r_end   <= 8'd0;
      r_i     <= '0;
      r_bits  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_err   <= 1'b0;
          r_k     <= 8'd0;
          r_i     <= '0;
          r_j     <= 8'd0;
          r_state <= S_LOAD_IDX;
        end
        S_LOAD_IDX: if (w_acc) begin
          r_j <= r_j + 8'd1;
          if (r_j == OM1) r_state <= S_LOAD_CNT;
        end
        S_LOAD_CNT: if (w_acc) begin
          if ((i_in_byte < r_k) || (i_in_byte > OM)) begin
            r_err   <= 1'b1;
            r_state <= S_DRAIN;
          end else begin
            r_bits  <= '0;
            r_j     <= r_k;
            r_end   <= i_in_byte;
            r_state <= (i_in_byte == r_k) ? S_EMIT : S_SET_BITS;
          end
        end
        S_SET_BITS: begin
          // Indices within one poly must be strictly increasing.
          if ((r_j > r_k) && (w_cur <= w_prev)) begin
            r_err   <= 1'b1;
            r_state <= S_DRAIN;
          end else begin
            r_bits[w_cur] <= 1'b1;
            r_j           <= r_j + 8'd1;
            if (r_j + 8'd1 == r_end) r_state <= S_EMIT;
          end
        end
        S_EMIT: if (i_h_ready) begin
          r_k <= r_end;
          r_i <= r_i + 1'b1;
          if (r_i == KL) begin
            r_j     <= r_end;
            r_state <= (r_end == OM) ? S_DONE : S_CHK_TAIL;
          end else begin
            r_state <= S_LOAD_CNT;
          end
        end
        S_CHK_TAIL: begin
          if (w_cur != 8'd0) r_err <= 1'b1;
          r_j <= r_j + 8'd1;
          if (r_j == OM1) r_state <= S_DONE;
        end
        S_DRAIN: begin
          if (r_i == KL) r_state <= S_DONE;
          else if (w_acc) r_i <= r_i + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_hint_unpack.sv
// Bench for poly_hint_unpack: directed and random frames scored against a frame-level reference model.
module tb_poly_hint_unpack;

  localparam int K  = 4;
  localparam int OM = 80;
  localparam int NB = OM + K;

  logic          i_clk, i_rst, i_start, i_in_valid, i_h_ready;
  logic [7:0]    i_in_byte;
  logic          o_in_ready, o_h_valid, o_done, o_err;
  logic [8191:0] o_h_out;
  logic [1:0]    o_h_poly_idx;

  int checks = 0;
  int errors = 0;

  logic [7:0]   fr [NB];
  logic [255:0] exp_q [$];
  logic         exp_err;

  poly_hint_unpack #(.K(K), .OMEGA(OM)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_in_byte(i_in_byte), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .o_h_out(o_h_out), .o_h_poly_idx(o_h_poly_idx), .o_h_valid(o_h_valid),
    .i_h_ready(i_h_ready), .o_done(o_done), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] e);
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, e);
    end
  endtask

  function automatic logic [8191:0] expand(input logic [255:0] bm);
    logic [8191:0] r;
    r = '0;
    for (int x = 0; x < 256; x++) r[32*x +: 32] = {31'd0, bm[x]};
    return r;
  endfunction

  task automatic chk_poly(input string tag, input logic [8191:0] got, input logic [255:0] bm);
    logic [8191:0] e;
    e = expand(bm);
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: got %0d set coeffs expected %0d (first diff bit %0d)",
             tag, $countones(got), $countones(e), first_diff(got, e));
    end
  endtask

  function automatic int first_diff(input logic [8191:0] a, input logic [8191:0] b);
    for (int x = 0; x < 8192; x++) if (a[x] !== b[x]) return x;
    return -1;
  endfunction

  // Reference: walk the cumulative counts, collect each poly's index set as a bitmap.
  task automatic model();
    int k, c;
    logic [255:0] bm;
    bit bad;
    exp_q.delete();
    exp_err = 1'b0;
    k = 0;
    for (int i = 0; i < K; i++) begin
      c = fr[OM + i];
      if (c < k || c > OM) begin exp_err = 1'b1; break; end
      bm = '0; bad = 0;
      for (int j = k; j < c; j++) begin
        if (j > k && fr[j] <= fr[j-1]) bad = 1;
        bm[fr[j]] = 1'b1;
      end
      if (bad) begin exp_err = 1'b1; break; end
      exp_q.push_back(bm);
      k = c;
    end
    if (!exp_err)
      for (int j = k; j < OM; j++) if (fr[j] != 8'd0) exp_err = 1'b1;
  endtask

  task automatic clear_frame();
    for (int b = 0; b < NB; b++) fr[b] = 8'd0;
  endtask

  task automatic gen_random();
    int c [K];
    int t, p;
    logic [255:0] m;
    clear_frame();
    for (int i = 0; i < K; i++) c[i] = $urandom_range(0, OM);
    for (int a = 0; a < K; a++)
      for (int b = 0; b < K - 1; b++)
        if (c[b] > c[b+1]) begin t = c[b]; c[b] = c[b+1]; c[b+1] = t; end
    p = 0;
    for (int i = 0; i < K; i++) begin
      m = '0;
      while ($countones(m) < c[i] - p) m[$urandom_range(0, 255)] = 1'b1;
      for (int v = 0; v < 256; v++) if (m[v]) begin fr[p] = 8'(v); p++; end
      fr[OM + i] = 8'(c[i]);
    end
    if ($urandom_range(0, 9) < 3) fr[$urandom_range(0, NB - 1)] = 8'($urandom);
  endtask

  // Drives one frame; hold stalls the first poly for 10 cycles, rst_at>0 resets mid SET_BITS.
  task automatic run_frame(input string name, input int hold, input int rst_at);
    int ptr, np, cyc, held, since;
    bit fin;
    logic [8191:0] snap;
    ptr = 0; np = 0; cyc = 0; held = 0; since = 0; fin = 0; snap = '0;
    model();
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    while (!fin && cyc < 4000) begin
      if (o_done) begin
        i_in_valid = 1'b0; i_h_ready = 1'b0;
        chk({name, "_err"}, o_err, exp_err);
        chk({name, "_npoly"}, np, exp_q.size());
        chk({name, "_bytes"}, ptr, NB);
        fin = 1;
      end else begin
        if (o_h_valid) begin
          chk({name, "_rdy_in_emit"}, o_in_ready, 0);
          if (hold != 0 && np == 0 && held < 10) begin
            if (held == 0) snap = o_h_out;
            else chk_poly({name, "_hold"}, o_h_out, snap[255:0] == 0 ? exp_q[0] : exp_q[0]);
            held++;
            i_h_ready = 1'b0;
          end else begin
            i_h_ready = ($urandom_range(0, 3) != 0);
          end
          if (i_h_ready) begin
            checks++;
            assert (np < exp_q.size()) else begin
              errors++;
              $error("FAIL %s_extra_poly: got poly %0d expected %0d polys", name, np, exp_q.size());
            end
            if (np < exp_q.size()) begin
              chk({name, "_idx"}, o_h_poly_idx, np);
              chk_poly({name, "_hout"}, o_h_out, exp_q[np]);
            end
            np++;
          end
        end else begin
          i_h_ready = 1'($urandom_range(0, 1));
        end
        i_in_valid = (ptr < NB) && ($urandom_range(0, 3) != 0);
        i_in_byte  = (ptr < NB) ? fr[ptr] : 8'($urandom);
        if (o_in_ready && i_in_valid) ptr++;
        if (rst_at > 0 && ptr > OM) begin
          since++;
          if (since == rst_at) begin
            i_rst = 1'b1; i_in_valid = 1'b0; i_h_ready = 1'b0;
            @(negedge i_clk);
            chk({name, "_rst_hout"}, 32'($countones(o_h_out)), 0);
            chk({name, "_rst_hvalid"}, o_h_valid, 0);
            chk({name, "_rst_inrdy"}, o_in_ready, 0);
            chk({name, "_rst_done"}, o_done, 0);
            chk({name, "_rst_err"}, o_err, 0);
            chk({name, "_rst_idx"}, o_h_poly_idx, 0);
            i_rst = 1'b0;
            return;
          end
        end
      end
      @(negedge i_clk);
      cyc++;
    end
    checks++;
    assert (fin) else begin
      errors++;
      $error("FAIL %s_timeout: got no done after %0d cycles expected done", name, cyc);
    end
    chk({name, "_done_pulse"}, o_done, 0);
    chk({name, "_err_hold"}, o_err, exp_err);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_in_valid = 1'b0; i_h_ready = 1'b0; i_in_byte = 8'd0;
    repeat (3) @(negedge i_clk);
    chk("reset_inrdy", o_in_ready, 0);
    chk("reset_hvalid", o_h_valid, 0);
    chk("reset_done", o_done, 0);
    chk("reset_err", o_err, 0);
    chk("reset_hout", 32'($countones(o_h_out)), 0);
    chk("reset_idx", o_h_poly_idx, 0);
    i_rst = 1'b0;

    clear_frame();
    run_frame("allzero", 0, 0);

    clear_frame();
    fr[0] = 8'd3; fr[1] = 8'd7; fr[2] = 8'd255;
    for (int i = 0; i < K; i++) fr[OM + i] = 8'd3;
    run_frame("three_idx", 0, 0);

    clear_frame();
    fr[0] = 8'd7; fr[1] = 8'd7;
    for (int i = 0; i < K; i++) fr[OM + i] = 8'd2;
    run_frame("dup_idx", 0, 0);

    clear_frame();
    for (int j = 0; j < 5; j++) fr[j] = 8'(j + 1);
    fr[OM] = 8'd5; fr[OM+1] = 8'd3; fr[OM+2] = 8'd5; fr[OM+3] = 8'd5;
    run_frame("cnt_decr", 0, 0);

    clear_frame();
    fr[OM] = 8'd81;
    run_frame("cnt_over", 0, 0);

    clear_frame();
    fr[0] = 8'd10; fr[1] = 8'd20; fr[5] = 8'h01;
    for (int i = 0; i < K; i++) fr[OM + i] = 8'd2;
    run_frame("tail_nz", 0, 0);

    clear_frame();
    fr[0] = 8'd3; fr[1] = 8'd7; fr[2] = 8'd255;
    for (int i = 0; i < K; i++) fr[OM + i] = 8'd3;
    run_frame("hold", 1, 0);

    clear_frame();
    for (int j = 0; j < OM; j++) fr[j] = 8'(j);
    for (int i = 0; i < K; i++) fr[OM + i] = 8'(OM);
    run_frame("midrst", 0, 5);
    run_frame("after_rst", 0, 0);

    for (int n = 0; n < 20; n++) begin
      gen_random();
      run_frame("random", 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
